scanline_prefetcher: RTL
========================

Name: scanline_prefetcher

Overview:
- Sits between the GPU framebuffer read port and the HDMI encoder, in the pixel_clk domain.
- Prefetches each visible line from the framebuffer into a ping-pong line buffer one line ahead of display.
- Emits RGB 3-3-2 pixels with hs/vs/vde delayed to match the pixel data.
- Decouples framebuffer read latency from the raster, so the GPU can use a deeper-latency BRAM port.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, pixel clocks per line
V_ACTIVE, 480, visible lines
V_TOTAL, 525, lines per frame
FB_ADDR_W, 19, framebuffer address width
RD_LAT, 2, framebuffer read latency in cycles (1..4)

Ports:
pixel_clk  in  1  pixel clock, 25 MHz
reset  in  1  asynchronous, active-high
hs_in  in  1  hsync from vga_controller
vs_in  in  1  vsync from vga_controller
vde_in  in  1  active video from vga_controller
drawX  in  10  current pixel column
drawY  in  10  current line
fb_rd_en  out  1  framebuffer read strobe
fb_addr  out  FB_ADDR_W  framebuffer byte address
fb_rdata  in  8  RGB332 pixel, valid RD_LAT cycles after fb_rd_en
red  out  3  pixel red
green  out  3  pixel green
blue  out  2  pixel blue
hs_out  out  1  hs_in delayed 2 cycles
vs_out  out  1  vs_in delayed 2 cycles
vde_out  out  1  vde_in delayed 2 cycles
underrun  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0; sel=0; FSM IDLE; underrun=0; delay pipes cleared. Line buffer contents are not reset, so the first partial frame after reset is undefined.
- Event cycle: drawX==H_TOTAL-1.
  - ny = next line, wrapping V_TOTAL-1 to 0.
  - f = ny+1, wrapping V_TOTAL to 0.
- At the event cycle:
  - If ny<V_ACTIVE, sel toggles, and the buffer just filled becomes front.
  - If f<V_ACTIVE, a fetch of line f into the back buffer (index ~sel_next) starts.
- Line 0 handling: its fetch starts at the end of line V_TOTAL-2 with no toggle, and it is displayed from line 0 onward.
- Fetch FSM:
  - IDLE -> FETCH on a fetch trigger.
  - FETCH: fb_rd_en=1, fb_addr = f*H_ACTIVE + cnt. cnt runs 0..H_ACTIVE-1, one read per cycle. Exit to DRAIN after cnt==H_ACTIVE-1.
  - DRAIN: RD_LAT cycles for the last returns, then IDLE.
  - A fetch takes H_ACTIVE+RD_LAT cycles, less than H_TOTAL.
- Write side: an RD_LAT-deep valid/index shift pipe captures fb_rdata into back[index].
- Address arithmetic: f*H_ACTIVE+cnt computed at full width, then truncated to FB_ADDR_W. The maximum, 307199, fits in 19 bits. The base is registered at trigger time.
- Collision: a trigger while FSM is not IDLE sets underrun (sticky until reset), aborts the in-flight fetch, discards pending returns, and restarts at the new f.
- Display path:
  - Cycle 0: front[drawX] is read.
  - Cycle 1: RAM data is valid.
  - Cycle 2: red=pix[7:5], green=pix[4:2], blue=pix[1:0] are registered.
- Colour outputs are forced to 0 when the delayed vde is 0.
- Sync outputs have exactly 2 cycles of latency. hs/vs polarity passes through unchanged.
- Out-of-range drawX (>=H_ACTIVE) never addresses the buffer; the read address clamps to 0 and the data is masked by vde.

Optional Feature:
- Macro: SCANLINE_PREFETCH_TEST_PATTERN_EN.
- When defined:
  - Adds input port pattern_sel (1 bit).
  - While pattern_sel=1, the pixel is {drawX[7:5], drawY[7:5], drawX[4:3]^drawY[4:3]}, using the same 2-cycle latency.
  - Fetching continues unaffected.
- When undefined: no port is added, and the behaviour is as above.

Decomposition:
- Package video_timing_pkg holds:
  - Constants H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL.
  - typedef rgb332_t (packed r[2:0], g[2:0], b[1:0]).
  - enum fetch_state_t {IDLE, FETCH, DRAIN}.
- Sub-module line_buffer_dp:
  - Simple dual-port RAM of 2*H_ACTIVE x 8, one write port and one read port.
  - 1-cycle registered read; infers BRAM.

Test Plan:
- Framebuffer model with value = addr[7:0], RD_LAT=2, two full frames -> line y pixel x output equals (y*640+x)[7:0] split 3-3-2, appearing 2 cycles after drawX=x; underrun stays 0.
- End of line 523 (drawX=799) -> fb_rd_en rises next cycle with fb_addr=0, increments to 639, then is low; sel unchanged.
- Line 479 -> no fetch issued during it, and none during lines 480..522; vde_out=0 gives RGB=0.
- Force a trigger while in FETCH (jump drawX to 799 mid-fetch) -> underrun=1 and stays 1; the fetch restarts at the new base; the next clean frame displays correctly.
- Assert reset mid-FETCH at line 200 -> all outputs 0 immediately (asynchronously); after release, the second full frame matches the model.
- RD_LAT=4 build -> same pixel results as the first scenario; fetch completes by drawX=644.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants, pixel format and fetch FSM encoding
// for the scanline prefetcher and its line buffer.
package video_timing_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_ACTIVE  = 480;
    localparam int V_TOTAL   = 525;

    localparam int LB_DEPTH  = 2 * H_ACTIVE;
    localparam int LB_ADDR_W = $clog2(LB_DEPTH);

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    // Half 0 occupies words 0..H_ACTIVE-1, half 1 the next H_ACTIVE words.
    function automatic logic [LB_ADDR_W-1:0] lb_addr(input logic half, input logic [9:0] col);
        return half ? LB_ADDR_W'(H_ACTIVE + int'(col)) : LB_ADDR_W'(col);
    endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line storage: 2*H_ACTIVE bytes, one write port, one read port
// with a single registered read stage.
module line_buffer_dp
    import video_timing_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [LB_ADDR_W-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [LB_ADDR_W-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [LB_DEPTH];

    // NOTE: neither the array nor the read register is reset; a reset here would stop block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/scanline_prefetcher.sv
// Prefetches each visible line one line ahead into a ping-pong buffer and
// replays it as RGB332 with 2-cycle aligned syncs. Option: SCANLINE_PREFETCH_TEST_PATTERN_EN.
module scanline_prefetcher
    import video_timing_pkg::*;
#(
    parameter int FB_ADDR_W = 19,
    parameter int RD_LAT    = 2
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 vde_in,
    input  logic [9:0]           drawX,
    input  logic [9:0]           drawY,
`ifdef SCANLINE_PREFETCH_TEST_PATTERN_EN
    input  logic                 pattern_sel,
`endif
    output logic                 fb_rd_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [7:0]           fb_rdata,
    output logic [2:0]           red,
    output logic [2:0]           green,
    output logic [1:0]           blue,
    output logic                 hs_out,
    output logic                 vs_out,
    output logic                 vde_out,
    output logic                 underrun
);

    localparam int DW = $clog2(RD_LAT + 1);

    logic [9:0]  ny, f;
    logic        ev, toggle, trigger, collision;
    logic        sel, sel_next;

    assign ev        = (drawX == 10'(H_TOTAL - 1));
    assign ny        = (drawY == 10'(V_TOTAL - 1)) ? '0 : drawY + 10'd1;
    assign f         = (ny == 10'(V_TOTAL - 1)) ? '0 : ny + 10'd1;
    assign toggle    = ev && (ny < 10'(V_ACTIVE));
    assign trigger   = ev && (f < 10'(V_ACTIVE));
    assign sel_next  = sel ^ toggle;

    fetch_state_t             state;
    logic [9:0]               cnt;
    logic [DW-1:0]            drain_cnt;
    logic [FB_ADDR_W-1:0]     base;
    logic                     fetch_idx;
    logic [31:0]              base_full, addr_full;

    assign collision = trigger && (state != IDLE);
    assign base_full = 32'(f) * 32'(H_ACTIVE);
    assign addr_full = 32'(base) + 32'(cnt);
    assign fb_rd_en  = (state == FETCH);
    assign fb_addr   = fb_rd_en ? FB_ADDR_W'(addr_full) : '0;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            base      <= '0;
            fetch_idx <= 1'b0;
            sel       <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            sel <= sel_next;
            if (trigger) begin
                if (collision) begin
                    underrun <= 1'b1;
                end
                state     <= FETCH;
                cnt       <= '0;
                base      <= FB_ADDR_W'(base_full);
                fetch_idx <= ~sel_next;
            end else begin
                case (state)
                    FETCH: begin
                        if (cnt == 10'(H_ACTIVE - 1)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == DW'(RD_LAT - 1)) begin
                            state <= IDLE;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Return pipe: tags each read with its buffer half and column until the data lands.
    logic [RD_LAT-1:0] vld_pipe, idx_pipe;
    logic [9:0]        col_pipe [RD_LAT];

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                col_pipe[i] <= '0;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
                col_pipe[i] <= col_pipe[i-1];
            end
            vld_pipe[0] <= fb_rd_en;
            idx_pipe[0] <= fetch_idx;
            col_pipe[0] <= cnt;
            if (collision) begin
                vld_pipe <= '0;
            end
        end
    end

    logic [9:0] rd_col;
    logic [7:0] rd_data;

    assign rd_col = (drawX < 10'(H_ACTIVE)) ? drawX : '0;

    line_buffer_dp u_line_buffer (
        .clk     (pixel_clk),
        .wr_en   (vld_pipe[RD_LAT-1]),
        .wr_addr (lb_addr(idx_pipe[RD_LAT-1], col_pipe[RD_LAT-1])),
        .wr_data (fb_rdata),
        .rd_addr (lb_addr(sel, rd_col)),
        .rd_data (rd_data)
    );

    rgb332_t pix;
    logic    hs_d1, vs_d1, vde_d1;

`ifdef SCANLINE_PREFETCH_TEST_PATTERN_EN
    logic       pat_d1;
    logic [4:0] x_d1, y_d1;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pat_d1 <= 1'b0;
            x_d1   <= '0;
            y_d1   <= '0;
        end else begin
            pat_d1 <= pattern_sel;
            x_d1   <= drawX[7:3];
            y_d1   <= drawY[7:3];
        end
    end

    assign pix = pat_d1 ? rgb332_t'({x_d1[4:2], y_d1[4:2], x_d1[1:0] ^ y_d1[1:0]})
                        : rgb332_t'(rd_data);
`else
    assign pix = rgb332_t'(rd_data);
`endif

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hs_d1   <= 1'b0;
            vs_d1   <= 1'b0;
            vde_d1  <= 1'b0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            vde_out <= 1'b0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else begin
            hs_d1   <= hs_in;
            vs_d1   <= vs_in;
            vde_d1  <= vde_in;
            hs_out  <= hs_d1;
            vs_out  <= vs_d1;
            vde_out <= vde_d1;
            red     <= vde_d1 ? pix.r : '0;
            green   <= vde_d1 ? pix.g : '0;
            blue    <= vde_d1 ? pix.b : '0;
        end
    end

endmodule
